// File: rtl/adc_uart_framer.sv
// Decimates the ADC ch1/ch2 sample stream and frames one snapshot pair as a 7-byte
// AXI-stream packet (sync, seq, ch1 hi/lo, ch2 hi/lo, check). Define ADC_UART_FRAMER_CRC8_EN for a CRC-8 check byte.
module adc_uart_framer #(
    parameter int          SAMPLE_WIDTH = 16,
    parameter int          DECIM_WIDTH  = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [DECIM_WIDTH-1:0]  i_decim,
    input  logic [SAMPLE_WIDTH-1:0] i_sample_ch1,
    input  logic [SAMPLE_WIDTH-1:0] i_sample_ch2,
    input  logic                    i_sample_valid,
    output logic [7:0]              o_tdata,
    output logic                    o_tvalid,
    input  logic                    i_tready,
    output logic                    o_busy,
    output logic [7:0]              o_drop_count
);

    // Handshake: a byte transfers on a clock edge where o_tvalid && i_tready; o_tvalid and
    // o_tdata are registers, held unchanged until that edge, and never depend on i_tready.
    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [DECIM_WIDTH-1:0]  cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [SAMPLE_WIDTH-1:0] ch1_q, ch1_d, ch2_q, ch2_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              chk_q, chk_d;
    logic [7:0]              tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic [7:0]              drop_q, drop_d;
    logic                    kept;
    logic                    accept;
    logic [7:0]              chk_upd;

`ifdef ADC_UART_FRAMER_CRC8_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
    assign chk_upd = crc8_step(chk_q, tdata_q);
`else
    assign chk_upd = chk_q + tdata_q;
`endif

    assign kept   = i_sample_valid && i_enable && (cnt_q == '0);
    assign accept = tvalid_q && i_tready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ch1_d    = ch1_q;
        ch2_d    = ch2_q;
        seq_d    = seq_q;
        chk_d    = chk_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        drop_d   = drop_q;

        if (!i_enable) begin
            cnt_d = '0;
        end else if (i_sample_valid) begin
            cnt_d = (cnt_q == '0) ? i_decim : cnt_q - DECIM_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (kept) begin
                    state_d  = SEND;
                    ch1_d    = i_sample_ch1;
                    ch2_d    = i_sample_ch2;
                    idx_d    = 3'd0;
                    chk_d    = 8'h00;
                    tvalid_d = 1'b1;
                    tdata_d  = SYNC_BYTE;
                end
            end
            SEND: begin
                if (kept && drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
                if (accept) begin
                    if (idx_q == 3'd6) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tdata_d  = 8'h00;
                        seq_d    = seq_q + 8'd1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        // the check accumulates bytes 1..5 as they leave
                        if (idx_q != 3'd0) begin
                            chk_d = chk_upd;
                        end
                        case (idx_q)
                            3'd0:    tdata_d = seq_q;
                            3'd1:    tdata_d = ch1_q[15:8];
                            3'd2:    tdata_d = ch1_q[7:0];
                            3'd3:    tdata_d = ch2_q[15:8];
                            3'd4:    tdata_d = ch2_q[7:0];
                            3'd5:    tdata_d = chk_upd;
                            default: tdata_d = tdata_q;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            ch1_q    <= '0;
            ch2_q    <= '0;
            seq_q    <= 8'h00;
            chk_q    <= 8'h00;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            drop_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ch1_q    <= ch1_d;
            ch2_q    <= ch2_d;
            seq_q    <= seq_d;
            chk_q    <= chk_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            drop_q   <= drop_d;
        end
    end

    assign o_tdata      = tdata_q;
    assign o_tvalid     = tvalid_q;
    assign o_busy       = (state_q == SEND);
    assign o_drop_count = drop_q;

endmodule

// File: tb/tb_adc_uart_framer.sv
// Bench for adc_uart_framer: transaction-level model fills an expected byte queue,
// a negedge monitor pops and compares every transferred byte and the status outputs.
module tb_adc_uart_framer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] i_decim;
    logic [15:0] i_sample_ch1;
    logic [15:0] i_sample_ch2;
    logic        i_sample_valid;
    logic [7:0]  o_tdata;
    logic        o_tvalid;
    logic        i_tready;
    logic        o_busy;
    logic [7:0]  o_drop_count;

    always #5 clk = ~clk;

    adc_uart_framer dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_decim        (i_decim),
        .i_sample_ch1   (i_sample_ch1),
        .i_sample_ch2   (i_sample_ch2),
        .i_sample_valid (i_sample_valid),
        .o_tdata        (o_tdata),
        .o_tvalid       (o_tvalid),
        .i_tready       (i_tready),
        .o_busy         (o_busy),
        .o_drop_count   (o_drop_count)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         tv_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int         cyc_q[$];

    // reference model state (frame-level view)
    int         m_cnt = 0;
    bit         m_busy = 1'b0;
    int         m_left = 0;
    logic [7:0] m_seq = 8'h00;
    logic [7:0] m_drops = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] check_ref(input logic [7:0] b1, input logic [7:0] b2,
                                             input logic [7:0] b3, input logic [7:0] b4,
                                             input logic [7:0] b5);
`ifdef ADC_UART_FRAMER_CRC8_EN
        logic [39:0] msg;
        logic [7:0]  crc;
        msg = {b1, b2, b3, b4, b5};
        crc = 8'h00;
        for (int i = 39; i >= 0; i--) begin
            crc = (crc[7] ^ msg[i]) ? ((crc << 1) ^ 8'h07) : (crc << 1);
        end
        return crc;
`else
        return 8'((int'(b1) + int'(b2) + int'(b3) + int'(b4) + int'(b5)) % 256);
`endif
    endfunction

    // model: advance at each active edge using the inputs being sampled there
    always @(posedge clk) begin
        bit kept, was_busy;
        cyc++;
        if (i_reset) begin
            exp_q.delete();
            m_cnt = 0; m_busy = 1'b0; m_left = 0; m_seq = 8'h00; m_drops = 8'h00;
        end else begin
            kept = i_sample_valid && i_enable && (m_cnt == 0);
            if (!i_enable) m_cnt = 0;
            else if (i_sample_valid) m_cnt = (m_cnt == 0) ? int'(i_decim) : m_cnt - 1;
            was_busy = m_busy;
            if (was_busy && i_tready) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_seq++;
                end
            end
            if (kept) begin
                if (was_busy) begin
                    if (m_drops != 8'hFF) m_drops++;
                end else begin
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(m_seq);
                    exp_q.push_back(i_sample_ch1[15:8]);
                    exp_q.push_back(i_sample_ch1[7:0]);
                    exp_q.push_back(i_sample_ch2[15:8]);
                    exp_q.push_back(i_sample_ch2[7:0]);
                    exp_q.push_back(check_ref(m_seq, i_sample_ch1[15:8], i_sample_ch1[7:0],
                                              i_sample_ch2[15:8], i_sample_ch2[7:0]));
                    m_busy = 1'b1;
                    m_left = 7;
                end
            end
        end
    end

    // monitor
    bit         hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    always @(negedge clk) begin
        chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
        chk("tvalid", {31'd0, o_tvalid}, {31'd0, m_busy});
        chk("drop_count", {24'd0, o_drop_count}, {24'd0, m_drops});
        if (hold_v) begin
            chk("stall_valid", {31'd0, o_tvalid}, 32'd1);
            chk("stall_data", {24'd0, o_tdata}, {24'd0, hold_d});
        end
        hold_v = o_tvalid && !i_tready && !i_reset;
        hold_d = o_tdata;
        if (o_tvalid) tv_cnt++;
        if (o_tvalid && i_tready && !i_reset) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL byte: got %0h expected none (cycle %0d)", o_tdata, cyc);
            end else begin
                chk("byte", {24'd0, o_tdata}, {24'd0, exp_q.pop_front()});
            end
            cap_q.push_back(o_tdata);
            cyc_q.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_sample_valid = 1'b0;
        step();
        step();
        i_reset = 1'b0;
        chk("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, o_tdata}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_drop", {24'd0, o_drop_count}, 32'd0);
        cap_q.delete();
        cyc_q.delete();
        tv_cnt = 0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        i_sample_valid = 1'b0;
        i_tready = 1'b1;
        while ((exp_q.size() != 0 || m_busy) && n < budget) begin
            step();
            n++;
        end
        step();
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic drive_sample(input logic [15:0] c1, input logic [15:0] c2);
        i_sample_ch1 = c1;
        i_sample_ch2 = c2;
        i_sample_valid = 1'b1;
        step();
        i_sample_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  g[7];
        logic [15:0] d1[32];
        int          s;
        int          n;

        i_reset = 1'b1; i_enable = 1'b0; i_decim = 16'd0; i_tready = 1'b1;
        i_sample_ch1 = 16'd0; i_sample_ch2 = 16'd0; i_sample_valid = 1'b0;
        g[0] = 8'hA5; g[1] = 8'h00; g[2] = 8'h12; g[3] = 8'h34; g[4] = 8'hAB; g[5] = 8'hCD;
`ifdef ADC_UART_FRAMER_CRC8_EN
        g[6] = check_ref(8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD);
`else
        g[6] = 8'hBE;
`endif

        // 1: single frame, full-rate acceptance, latency one clock
        do_reset();
        i_enable = 1'b1;
        drive_sample(16'h1234, 16'hABCD);
        s = cyc;
        drain(50);
        chk("s1_count", cap_q.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk("s1_golden", {24'd0, cap_q[i]}, {24'd0, g[i]});
            chk("s1_timing", cyc_q[i], s + i);
        end

        // 2: tready toggling, 14 valid cycles
        do_reset();
        i_sample_ch1 = 16'h1234; i_sample_ch2 = 16'hABCD;
        for (int i = 0; i < 20; i++) begin
            i_sample_valid = (i == 0);
            i_tready = (i % 2 == 0);
            step();
        end
        drain(50);
        chk("s2_tvalid_cycles", tv_cnt, 32'd14);
        for (int i = 0; i < 7; i++) chk("s2_golden", {24'd0, cap_q[i]}, {24'd0, g[i]});

        // 3: decimation by 4
        do_reset();
        i_decim = 16'd3;
        for (int k = 0; k < 12; k++) begin
            d1[k] = 16'($urandom);
            drive_sample(d1[k], 16'($urandom));
            repeat (9) step();
        end
        drain(50);
        chk("s3_bytes", cap_q.size(), 32'd21);
        chk("s3_seq1", {24'd0, cap_q[8]}, 32'd1);
        chk("s3_seq2", {24'd0, cap_q[15]}, 32'd2);
        chk("s3_f0", {24'd0, cap_q[2]}, {24'd0, d1[0][15:8]});
        chk("s3_f1", {24'd0, cap_q[9]}, {24'd0, d1[4][15:8]});
        chk("s3_f2", {24'd0, cap_q[16]}, {24'd0, d1[8][15:8]});

        // 4: back-to-back strobes, drops while busy
        do_reset();
        i_decim = 16'd0;
        for (int k = 0; k < 20; k++) begin
            d1[k] = 16'($urandom);
            i_sample_ch1 = d1[k];
            i_sample_ch2 = 16'($urandom);
            i_sample_valid = 1'b1;
            step();
        end
        drain(50);
        chk("s4_drops", {24'd0, o_drop_count}, 32'd17);
        chk("s4_bytes", cap_q.size(), 32'd21);
        chk("s4_f0", {16'd0, cap_q[2], cap_q[3]}, {16'd0, d1[0]});
        chk("s4_f1", {16'd0, cap_q[9], cap_q[10]}, {16'd0, d1[8]});
        chk("s4_f2", {16'd0, cap_q[16], cap_q[17]}, {16'd0, d1[16]});

        // 5: 300 frames, seq wrap and drop saturation
        do_reset();
        for (int k = 0; k < 2400; k++) begin
            i_sample_ch1 = 16'($urandom);
            i_sample_ch2 = 16'($urandom);
            i_sample_valid = 1'b1;
            step();
        end
        drain(50);
        chk("s5_bytes", cap_q.size(), 32'd2100);
        chk("s5_seq_ff", {24'd0, cap_q[7*255+1]}, 32'hFF);
        chk("s5_seq_wrap", {24'd0, cap_q[7*256+1]}, 32'h00);
        chk("s5_drop_sat", {24'd0, o_drop_count}, 32'd255);

        // 6: reset while byte 3 is presented
        cap_q.delete();
        drive_sample(16'($urandom), 16'($urandom));
        n = 0;
        while (cap_q.size() < 3 && n < 20) begin
            step();
            n++;
        end
        chk("s6_reached_b3", cap_q.size(), 32'd3);
        i_tready = 1'b0;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("s6_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("s6_busy", {31'd0, o_busy}, 32'd0);
        chk("s6_drop", {24'd0, o_drop_count}, 32'd0);
        cap_q.delete();
        i_tready = 1'b1;
        drive_sample(16'($urandom), 16'($urandom));
        drain(50);
        chk("s6_sync", {24'd0, cap_q[0]}, 32'hA5);
        chk("s6_seq0", {24'd0, cap_q[1]}, 32'h00);

        // 7: random traffic with enable, tready and ratio changes
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            i_enable = ($urandom_range(0, 15) != 0);
            i_sample_valid = ($urandom_range(0, 1) == 1);
            i_tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) i_decim = 16'($urandom_range(0, 3));
            i_sample_ch1 = 16'($urandom);
            i_sample_ch2 = 16'($urandom);
            step();
        end
        i_enable = 1'b1;
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
